rs_msg_source: RTL and testbench

//  Parametrised message-symbol generator feeding the RS encoder input. On a start edge, emits one

---
 rtl/rs_msg_source_pkg.sv | 33 +++
 rtl/rs_msg_source_if.sv | 22 ++
 rtl/rs_msg_source_alpha_step.sv | 14 +
 rtl/rs_msg_source.sv | 145 ++++++++++++++
 tb/tb_rs_msg_source.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_msg_source_pkg.sv
// Shared types and GF(2^M) helpers for the RS message source and encoder.
// Symbols are carried in 8 bits so one helper serves every symbol width from 3 to 8.
package rs_pkg;

    typedef enum logic [1:0] {
        MODE_POWER = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_PRBS  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply by alpha in GF(2^m); poly holds the low m bits of the primitive polynomial.
    function automatic logic [7:0] gf_mul_alpha(input logic [7:0] sym,
                                                input logic [7:0] poly,
                                                input int unsigned m);
        logic [7:0] mask;
        logic [7:0] res;
        mask = 8'hFF >> (8 - m);
        res  = (sym << 1) & mask;
        if (sym[3'(m - 1)]) begin
            res = res ^ (poly & mask);
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_msg_source_if.sv
// Control and valid/ready symbol stream between the message source and its consumer.
interface rs_msg_source_if #(parameter int unsigned M = 4);
    logic         start;
    logic [1:0]   mode;
    logic [M-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sop;
    logic         out_eop;
    logic         busy;
    logic         done;

    modport master (
        input  start, mode, out_ready,
        output out_data, out_valid, out_sop, out_eop, busy, done
    );

    modport slave (
        output start, mode, out_ready,
        input  out_data, out_valid, out_sop, out_eop, busy, done
    );
endinterface

// File: rtl/rs_msg_source_alpha_step.sv
// Combinational multiply-by-alpha in GF(2^M).
module gf_alpha_step
    import rs_pkg::*;
#(
    parameter int unsigned M         = 4,
    parameter int unsigned PRIM_POLY = 'h3
) (
    input  logic [M-1:0] sym_i,
    output logic [M-1:0] sym_o
);

    assign sym_o = M'(gf_mul_alpha(8'(sym_i), 8'(PRIM_POLY), M));

endmodule

// File: rtl/rs_msg_source.sv
// Frame generator: on a start edge emits K GF(2^M) symbols (alpha powers, counter or
// free-running PRBS) over valid/ready with sop/eop framing, then pulses done.
module rs_msg_source
    import rs_pkg::*;
#(
    parameter int unsigned M         = 4,
    parameter int unsigned K         = 11,
    parameter int unsigned PRIM_POLY = 'h3,
    parameter int unsigned SEED      = 1
) (
    input  logic            clk,
    input  logic            rst,
    rs_msg_source_if.master bus
);

    localparam int unsigned    CW        = $clog2(K + 1);
    localparam logic [CW-1:0]  LAST      = CW'(K - 1);
    localparam logic [M-1:0]   ONE       = M'(1);
    localparam logic [M-1:0]   SEED_V    = (SEED == 0) ? M'(1) : M'(SEED);
    localparam logic           EOP_FIRST = (K == 1) ? 1'b1 : 1'b0;

    state_e        state_q;
    mode_e         mode_q;
    logic [CW-1:0] cnt_q;
    logic [M-1:0]  out_data_q;
    logic [M-1:0]  prbs_q;
    logic          start_q;
    logic          valid_q;
    logic          sop_q;
    logic          eop_q;
    logic          busy_q;
    logic          done_q;

    logic          accept;
    logic          xfer;
    logic [CW-1:0] cnt_inc;
    logic [M-1:0]  pow_next;
    logic [M-1:0]  prbs_next;
    logic [M-1:0]  sym_next;
    logic [M-1:0]  first_sym;
    mode_e         mode_sel;

    gf_alpha_step #(.M(M), .PRIM_POLY(PRIM_POLY)) u_pow_step (
        .sym_i (out_data_q),
        .sym_o (pow_next)
    );

    gf_alpha_step #(.M(M), .PRIM_POLY(PRIM_POLY)) u_prbs_step (
        .sym_i (prbs_q),
        .sym_o (prbs_next)
    );

    // Start qualification and handshake decode; a start edge during RUN is dropped.
    always_comb begin
        accept  = bus.start & ~start_q & (state_q != ST_RUN);
        xfer    = valid_q & bus.out_ready;
        cnt_inc = cnt_q + CW'(1);
    end

    // Symbol selection: first symbol from the requested mode, next symbol from the latched mode.
    always_comb begin
        mode_sel  = MODE_COUNT;
        first_sym = ONE;
        sym_next  = out_data_q + ONE;
        case (bus.mode)
            2'd0:    mode_sel = MODE_POWER;
            2'd2:    mode_sel = MODE_PRBS;
            default: mode_sel = MODE_COUNT;
        endcase
        case (mode_sel)
            MODE_PRBS: first_sym = prbs_q;
            default:   first_sym = ONE;
        endcase
        case (mode_q)
            MODE_POWER: sym_next = pow_next;
            MODE_PRBS:  sym_next = prbs_next;
            default:    sym_next = out_data_q + ONE;
        endcase
    end

    // Frame FSM with registered stream outputs; the PRBS state survives everything but rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_POWER;
            cnt_q      <= {CW{1'b0}};
            out_data_q <= {M{1'b0}};
            prbs_q     <= SEED_V;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= bus.start;
            case (state_q)
                ST_RUN: begin
                    if (xfer) begin
                        if (mode_q == MODE_PRBS) begin
                            prbs_q <= prbs_next;
                        end
                        if (cnt_q == LAST) begin
                            state_q <= ST_DONE;
                            cnt_q   <= {CW{1'b0}};
                            valid_q <= 1'b0;
                            sop_q   <= 1'b0;
                            eop_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_inc;
                            out_data_q <= sym_next;
                            sop_q      <= 1'b0;
                            eop_q      <= (cnt_inc == LAST);
                        end
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q    <= ST_RUN;
                        mode_q     <= mode_sel;
                        cnt_q      <= {CW{1'b0}};
                        out_data_q <= first_sym;
                        valid_q    <= 1'b1;
                        sop_q      <= 1'b1;
                        eop_q      <= EOP_FIRST;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_sop   = sop_q;
    assign bus.out_eop   = eop_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_rs_msg_source.sv
// Self-checking bench for rs_msg_source: table-driven frames with a scoreboard, plus
// hand-written start/reset corner sequences and a K=1, M=8 instance.
module tb_rs_msg_source;
    import rs_pkg::*;

    localparam int K = 11;

    typedef struct {
        logic [1:0] mode;
        int         rmode;      // 0 ready high, 1 toggle, 2 random
        int         exp_valid;  // expected valid/busy cycles, -1 when ready is random
        int         lit;        // 1 alpha-power literal list, 2 second PRBS frame prefix
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_msg_source_if #(.M(4)) bus ();
    rs_msg_source_if #(.M(8)) bus2 ();

    rs_msg_source #(.M(4), .K(11), .PRIM_POLY('h3), .SEED(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rs_msg_source #(.M(8), .K(1), .PRIM_POLY('h1D), .SEED(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int compared   = 0;
    int mismatched = 0;
    int valid_cyc  = 0;
    int busy_cyc   = 0;
    int done_cnt   = 0;

    exp_t       sb [$];
    logic [3:0] got [$];
    logic       prev_last  = 1'b0;
    logic       stall_prev = 1'b0;
    logic [3:0] hold_d     = 4'd0;
    logic       hold_s     = 1'b0;
    logic       hold_e     = 1'b0;
    logic [3:0] prbs_m     = 4'd1;

    logic [3:0] lit1 [0:10] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd6, 4'd12, 4'd11, 4'd5, 4'd10, 4'd7};
    logic [3:0] lit2 [0:4]  = '{4'd14, 4'd15, 4'd13, 4'd9, 4'd1};

    vec_t vecs [0:6];

    function automatic logic [3:0] m4(input logic [3:0] s);
        return {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [7:0] m8(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Samples the stream at the falling edge: scoreboard, stall stability, done timing, counters.
    task automatic mon();
        exp_t e;
        if (rst) begin
            prev_last  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (bus.out_valid) valid_cyc++;
            if (bus.busy) busy_cyc++;
            check("done_timing", bus.done, prev_last);
            if (bus.done) done_cnt++;
            if (stall_prev) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, hold_d);
                check("stall_sop", bus.out_sop, hold_s);
                check("stall_eop", bus.out_eop, hold_e);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_xfer: got data %0d, want no transfer (t=%0t)", bus.out_data, $time);
                end else begin
                    e = sb.pop_front();
                    check("xfer_data", bus.out_data, e.data);
                    check("xfer_sop", bus.out_sop, e.sop);
                    check("xfer_eop", bus.out_eop, e.eop);
                end
                got.push_back(bus.out_data);
            end
            prev_last  = bus.out_valid & bus.out_ready & bus.out_eop;
            stall_prev = bus.out_valid & ~bus.out_ready;
            hold_d     = bus.out_data;
            hold_s     = bus.out_sop;
            hold_e     = bus.out_eop;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [1:0] mode);
        exp_t e;
        logic [3:0] p;
        p = 4'd1;
        for (int n = 0; n < K; n++) begin
            e.sop = (n == 0);
            e.eop = (n == K - 1);
            case (mode)
                2'd0: begin e.data = p; p = m4(p); end
                2'd2: begin e.data = prbs_m; prbs_m = m4(prbs_m); end
                default: e.data = 4'(n + 1);
            endcase
            sb.push_back(e);
        end
    endtask

    task automatic set_ready(input int rmode);
        case (rmode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_frame(input vec_t v);
        int v0, b0, d0;
        v0 = valid_cyc;
        b0 = busy_cyc;
        d0 = done_cnt;
        got.delete();
        push_frame(v.mode);
        bus.mode      = v.mode;
        bus.start     = 1'b1;
        bus.out_ready = (v.rmode == 1) ? 1'b0 : 1'b1;
        tick();
        bus.start = 1'b0;
        set_ready(v.rmode);
        for (int c = 0; c < 300 && done_cnt == d0; c++) begin
            tick();
            set_ready(v.rmode);
        end
        check("frame_done", done_cnt - d0, 1);
        check("frame_sb_left", sb.size(), 0);
        sb.delete();
        if (v.exp_valid >= 0) begin
            check("valid_cycles", valid_cyc - v0, v.exp_valid);
            check("busy_cycles", busy_cyc - b0, v.exp_valid);
        end
        if (v.lit == 1) begin
            check("pow_seq_len", got.size(), 11);
            for (int i = 0; i < 11; i++)
                if (i < got.size()) check("pow_seq", got[i], lit1[i]);
        end
        if (v.lit == 2) begin
            for (int i = 0; i < 5; i++)
                if (i < got.size()) check("prbs_cont", got[i], lit2[i]);
        end
    endtask

    initial begin
        int d0, v0;
        logic [7:0] p2;

        vecs[0] = '{2'd0, 0, 11, 1};
        vecs[1] = '{2'd1, 1, 21, 0};
        vecs[2] = '{2'd2, 0, 11, 1};
        vecs[3] = '{2'd2, 0, 11, 2};
        vecs[4] = '{2'd3, 1, 21, 0};
        vecs[5] = '{2'd0, 2, -1, 0};
        vecs[6] = '{2'd2, 2, -1, 0};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.mode       = 2'd0;
        bus.out_ready  = 1'b1;
        bus2.start     = 1'b0;
        bus2.mode      = 2'd2;
        bus2.out_ready = 1'b1;
        tick();
        tick();
        check("rst_data", bus.out_data, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_sop", bus.out_sop, 0);
        check("rst_eop", bus.out_eop, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Start held high with an extra edge in RUN and one on the last transfer: one frame only.
        d0 = done_cnt;
        v0 = valid_cyc;
        push_frame(2'd0);
        bus.mode      = 2'd0;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        for (int c = 1; c <= 40; c++) begin
            tick();
            bus.start = (c < 40) && (c != 3) && (c != 9);
        end
        tick();
        check("hold_frames", done_cnt - d0, 1);
        check("hold_valid", valid_cyc - v0, 11);
        check("hold_sb_left", sb.size(), 0);
        check("hold_idle", bus.out_valid, 0);
        sb.delete();

        // Edge in the DONE cycle starts the next frame immediately.
        d0 = done_cnt;
        push_frame(2'd0);
        push_frame(2'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (11) tick();
        check("done_cycle", bus.done, 1);
        bus.start = 1'b1;
        tick();
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_sop", bus.out_sop, 1);
        check("b2b_data", bus.out_data, 1);
        check("b2b_busy", bus.busy, 1);
        check("b2b_done", bus.done, 0);
        bus.start = 1'b0;
        for (int c = 0; c < 100 && done_cnt - d0 < 2; c++) tick();
        check("b2b_frames", done_cnt - d0, 2);
        check("b2b_sb_left", sb.size(), 0);
        sb.delete();

        // Asynchronous reset mid-frame abandons the frame.
        d0 = done_cnt;
        push_frame(2'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("pre_rst_data", bus.out_data, 6);
        #2;
        rst = 1'b1;
        #1;
        check("arst_data", bus.out_data, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_sop", bus.out_sop, 0);
        check("arst_eop", bus.out_eop, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_no_done", done_cnt - d0, 0);
        prbs_m = 4'd1;
        run_frame('{2'd2, 0, 11, 1});
        run_frame('{2'd0, 0, 11, 1});

        // K=1, M=8 instance: single-symbol frames, PRBS walks all 255 alpha powers.
        p2 = 8'd1;
        for (int f = 0; f < 256; f++) begin
            bus2.start = 1'b1;
            tick();
            bus2.start = 1'b0;
            check("k1_valid", bus2.out_valid, 1);
            check("k1_sop", bus2.out_sop, 1);
            check("k1_eop", bus2.out_eop, 1);
            check("k1_data", bus2.out_data, p2);
            if (f == 255) check("k1_wrap", bus2.out_data, 8'h01);
            tick();
            check("k1_done", bus2.done, 1);
            check("k1_idle", bus2.out_valid, 0);
            p2 = m8(p2);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
